// File: rtl/fp64_normalise_pack.sv
// Post-adder packing stage for the double-precision datapath.
// Normalises the extended mantissa one bit per cycle, rounds to nearest-even
// and packs an IEEE-754 double. NaN/Inf are resolved on entry and subnormal
// results are flushed to zero.
//
// Handshake: start is sampled only in IDLE; an accepted start raises busy,
// which stays high through the single-cycle ready pulse in DONE. Starts seen
// while busy (including the DONE cycle) are dropped, not queued. result,
// overflow and underflow only change on the transition into DONE and then
// hold until the next accepted operation completes.
module fp64_normalise_pack #(
  parameter int MAX_SHIFT = 55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_in,
  input  logic [11:0] exp_in,
  input  logic [55:0] mant_in,
  input  logic        sticky_in,
  input  logic        nan_in,
  input  logic        inf_in,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  // state is the observation point for the FSM
  state_t      state, state_nx;
  logic [55:0] mant, mant_nx;
  logic [11:0] exp_r, exp_nx;
  logic        sticky, sticky_nx;
  logic        sign, sign_nx;
  logic [5:0]  shift_cnt, shift_cnt_nx;
  logic [63:0] result_nx;
  logic        overflow_nx, underflow_nx;

  logic        inc;
  logic [53:0] rnd_sum;
  logic [12:0] rnd_exp;
  logic [51:0] rnd_frac;

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);

  // Round-to-nearest-even on the normalised significand held in mant[55:2];
  // a rounding carry into bit 55 renormalises by one and bumps the exponent.
  always_comb begin
    inc     = mant[1] & (mant[0] | sticky | mant[2]);
    rnd_sum = mant[55:2] + 54'(inc);
    rnd_exp = {1'b0, exp_r} + 13'(rnd_sum[53]);
    if (rnd_sum[53]) begin
      rnd_frac = rnd_sum[52:1];
    end else begin
      rnd_frac = rnd_sum[51:0];
    end
  end

  // Next-state and datapath update for each FSM state
  always_comb begin
    state_nx     = state;
    mant_nx      = mant;
    exp_nx       = exp_r;
    sticky_nx    = sticky;
    sign_nx      = sign;
    shift_cnt_nx = shift_cnt;
    result_nx    = result;
    overflow_nx  = overflow;
    underflow_nx = underflow;

    case (state)
      IDLE: begin
        if (start) begin
          mant_nx      = mant_in;
          exp_nx       = exp_in;
          sticky_nx    = sticky_in;
          sign_nx      = sign_in;
          shift_cnt_nx = 6'd0;
          if (nan_in) begin
            result_nx    = 64'h7FF8000000000000;
            overflow_nx  = 1'b0;
            underflow_nx = 1'b0;
            state_nx     = DONE;
          end else if (inf_in) begin
            result_nx    = {sign_in, 11'h7FF, 52'h0};
            overflow_nx  = 1'b0;
            underflow_nx = 1'b0;
            state_nx     = DONE;
          end else if ((mant_in == 56'h0) && !sticky_in) begin
            result_nx    = {sign_in, 63'h0};
            overflow_nx  = 1'b0;
            underflow_nx = 1'b0;
            state_nx     = DONE;
          end else begin
            state_nx = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (mant[55]) begin
          // Carry from the adder: one right shift, then straight to rounding
          mant_nx   = {1'b0, mant[55:1]};
          sticky_nx = sticky | mant[0];
          exp_nx    = exp_r + 12'd1;
          state_nx  = ROUND;
        end else if (!mant[54]) begin
          if ((exp_r == 12'd1) || (shift_cnt == 6'(MAX_SHIFT - 1))) begin
            // Would go subnormal (or never normalises): flush to zero
            result_nx    = {sign, 63'h0};
            overflow_nx  = 1'b0;
            underflow_nx = 1'b1;
            state_nx     = DONE;
          end else begin
            mant_nx      = {mant[54:0], 1'b0};
            exp_nx       = exp_r - 12'd1;
            shift_cnt_nx = shift_cnt + 6'd1;
          end
        end else begin
          state_nx = ROUND;
        end
      end

      ROUND: begin
        if (rnd_exp >= 13'd2047) begin
          result_nx    = {sign, 11'h7FF, 52'h0};
          overflow_nx  = 1'b1;
          underflow_nx = 1'b0;
        end else if (rnd_exp == 13'd0) begin
          result_nx    = {sign, 63'h0};
          overflow_nx  = 1'b0;
          underflow_nx = 1'b1;
        end else begin
          result_nx    = {sign, rnd_exp[10:0], rnd_frac};
          overflow_nx  = 1'b0;
          underflow_nx = 1'b0;
        end
        state_nx = DONE;
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mant      <= 56'h0;
      exp_r     <= 12'h0;
      sticky    <= 1'b0;
      sign      <= 1'b0;
      shift_cnt <= 6'd0;
      result    <= 64'h0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nx;
      mant      <= mant_nx;
      exp_r     <= exp_nx;
      sticky    <= sticky_nx;
      sign      <= sign_nx;
      shift_cnt <= shift_cnt_nx;
      result    <= result_nx;
      overflow  <= overflow_nx;
      underflow <= underflow_nx;
    end
  end

endmodule

// File: tb/tb_fp64_normalise_pack.sv
// Bench for fp64_normalise_pack: directed vector table, hand-written
// reset/busy sequences, and randomized operations against a reference model.
module tb_fp64_normalise_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign_in;
  logic [11:0] exp_in;
  logic [55:0] mant_in;
  logic        sticky_in;
  logic        nan_in;
  logic        inf_in;
  logic        busy;
  logic        ready;
  logic [63:0] result;
  logic        overflow;
  logic        underflow;

  fp64_normalise_pack #(.MAX_SHIFT(55)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .sticky_in (sticky_in),
    .nan_in    (nan_in),
    .inf_in    (inf_in),
    .busy      (busy),
    .ready     (ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [11:0] exp;
    logic [55:0] mant;
    logic        sticky;
    logic        nan;
    logic        inf;
    logic [63:0] res;
    logic        ovf;
    logic        unf;
    int          lat;   // edges after the accepting edge; -1 = not checked
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: expected results queued per issued operation
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference model: locate the leading one, normalise in one step,
  // round with integer arithmetic, then classify the exponent.
  function automatic vec_t model(input vec_t v);
    vec_t o;
    int          p, n, e;
    logic [55:0] m;
    logic        st;
    longint unsigned keep;
    logic        g, r, lsb, incr;
    o = v; o.ovf = 1'b0; o.unf = 1'b0;
    e = int'(v.exp); m = v.mant; st = v.sticky;
    if (v.nan) begin o.res = 64'h7FF8000000000000; o.lat = 0; return o; end
    if (v.inf) begin o.res = {v.sign, 11'h7FF, 52'h0}; o.lat = 0; return o; end
    if (m == 56'h0 && !st) begin o.res = {v.sign, 63'h0}; o.lat = 0; return o; end
    if (m == 56'h0) begin
      o.res = {v.sign, 63'h0}; o.unf = 1'b1;
      o.lat = (e >= 1 && e <= 55) ? e : 55;
      return o;
    end
    p = 0;
    for (int i = 0; i < 56; i++) if (m[i]) p = i;
    if (p == 55) begin
      st = st | m[0]; m = m >> 1; e = e + 1; o.lat = 2;
    end else begin
      n = 54 - p;
      if (n > 0 && e >= 1 && e <= n) begin
        o.res = {v.sign, 63'h0}; o.unf = 1'b1; o.lat = e;
        return o;
      end
      m = m << n; e = e - n; o.lat = n + 2;
    end
    keep = longint'(m) >> 2;
    g = m[1]; r = m[0]; lsb = m[2];
    incr = g & (r | st | lsb);
    keep = keep + (incr ? 64'd1 : 64'd0);
    if (keep >= (64'd1 << 53)) begin keep = keep >> 1; e = e + 1; end
    if (e >= 2047) begin
      o.res = {v.sign, 11'h7FF, 52'h0}; o.ovf = 1'b1;
    end else if (e == 0) begin
      o.res = {v.sign, 63'h0}; o.unf = 1'b1;
    end else begin
      o.res = {v.sign, 11'(e), keep[51:0]};
    end
    return o;
  endfunction

  // driver tasks (called at #1 after a rising edge)
  task automatic drive(input vec_t v);
    sign_in = v.sign; exp_in = v.exp; mant_in = v.mant;
    sticky_in = v.sticky; nan_in = v.nan; inf_in = v.inf;
  endtask

  task automatic issue(input vec_t v);
    drive(v);
    start = 1'b1;
    @(posedge clk); #1;   // edge 0
    start = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (ready) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string name, input vec_t v, input vec_t e);
    int lat;
    logic [63:0] expected;
    issue(v);
    exp_q.push_back(e.res);
    wait_ready(lat);
    expected = exp_q.pop_front();
    if (lat < 0) begin
      check({name, " timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, " result"}, result, expected);
      check({name, " overflow"}, 64'(overflow), 64'(e.ovf));
      check({name, " underflow"}, 64'(underflow), 64'(e.unf));
      check({name, " busy@ready"}, 64'(busy), 64'd1);
      if (e.lat >= 0) check({name, " latency"}, 64'(lat), 64'(e.lat));
      @(posedge clk); #1;
      check({name, " idle"}, 64'({busy, ready}), 64'd0);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [11:0] ex, input logic [55:0] m,
                              input logic st, input logic na, input logic in,
                              input logic [63:0] res, input logic ov, input logic un,
                              input int lat);
    vec_t v;
    v.sign = s; v.exp = ex; v.mant = m; v.sticky = st; v.nan = na; v.inf = in;
    v.res = res; v.ovf = ov; v.unf = un; v.lat = lat;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t one_v, slow_v, nan_v, rv, ev;
  logic [55:0] one56, m_rnd;
  int lat, saw_ready;

  initial begin
    one56 = 56'd1;
    // directed vectors: inputs and hand-computed expectations
    tbl.push_back(mk(0, 1023, one56 << 54, 0, 0, 0, 64'h3FF0000000000000, 0, 0, 2));
    tbl.push_back(mk(0, 1023, one56 << 55, 0, 0, 0, 64'h4000000000000000, 0, 0, 2));
    tbl.push_back(mk(0, 1023, one56 << 50, 0, 0, 0, 64'h3FB0000000000000, 0, 0, 6));
    tbl.push_back(mk(0, 1023, (one56 << 54) | 56'd2, 0, 0, 0, 64'h3FF0000000000000, 0, 0, 2));
    tbl.push_back(mk(0, 1023, (one56 << 54) | 56'd6, 0, 0, 0, 64'h3FF0000000000002, 0, 0, 2));
    tbl.push_back(mk(0, 1023, (one56 << 54) | 56'd2, 1, 0, 0, 64'h3FF0000000000001, 0, 0, 2));
    tbl.push_back(mk(0, 2046, 56'h7F_FFFF_FFFF_FFFF, 0, 0, 0, 64'h7FF0000000000000, 1, 0, 2));
    tbl.push_back(mk(1, 1023, one56 << 54, 0, 1, 1, 64'h7FF8000000000000, 0, 0, -1));
    tbl.push_back(mk(1, 1023, one56 << 54, 0, 0, 1, 64'hFFF0000000000000, 0, 0, -1));
    tbl.push_back(mk(1, 1023, 56'h0, 0, 0, 0, 64'h8000000000000000, 0, 0, -1));
    tbl.push_back(mk(0, 1023, 56'h0, 1, 0, 0, 64'h0000000000000000, 0, 1, -1));
    tbl.push_back(mk(1, 3, one56 << 40, 0, 0, 0, 64'h8000000000000000, 0, 1, -1));
    tbl.push_back(mk(0, 0, one56 << 54, 0, 0, 0, 64'h0000000000000000, 0, 1, 2));
    tbl.push_back(mk(0, 2047, one56 << 54, 0, 0, 0, 64'h7FF0000000000000, 1, 0, 2));
    tbl.push_back(mk(1, 1, one56 << 55, 1, 0, 0, 64'h8020000000000000, 0, 0, 2));

    start = 0; sign_in = 0; exp_in = 0; mant_in = 0;
    sticky_in = 0; nan_in = 0; inf_in = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", {59'd0, busy, ready, overflow, underflow, 1'b0}, 64'd0);
    check("reset result", result, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_op($sformatf("vec%0d", i), tbl[i], tbl[i]);

    // reset in SHIFT aborts; no ready pulse afterwards
    one_v  = tbl[0];
    slow_v = tbl[2];
    issue(slow_v);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort outputs", {59'd0, busy, ready, overflow, underflow, 1'b0}, 64'd0);
    check("abort result", result, 64'h0);
    saw_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (ready || busy) saw_ready = 1;
      @(posedge clk); #1;
    end
    check("abort no ready", 64'(saw_ready), 64'd0);
    run_op("after abort", one_v, one_v);

    // start while busy and during DONE is dropped
    nan_v = tbl[7];
    issue(slow_v);
    drive(nan_v);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_ready(lat);
    check("busy start lat", 64'(lat), 64'd4);
    check("busy start result", result, 64'h3FB0000000000000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done start busy", 64'({busy, ready}), 64'd0);
    check("done start held", result, 64'h3FB0000000000000);
    @(posedge clk); #1;
    check("done start stays idle", 64'(busy), 64'd0);

    // randomized operations against the reference model
    for (int i = 0; i < 300; i++) begin
      int p;
      m_rnd = 56'({$urandom, $urandom});
      p = $urandom_range(0, 55);
      m_rnd = (m_rnd & ((one56 << p) - 56'd1)) | (one56 << p);
      if ($urandom_range(0, 19) == 0) m_rnd = 56'h0;
      rv.sign = 1'($urandom);
      rv.exp = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(1, 60))
                                            : 12'($urandom_range(1, 2100));
      rv.mant = m_rnd;
      rv.sticky = 1'($urandom);
      rv.nan = ($urandom_range(0, 29) == 0);
      rv.inf = ($urandom_range(0, 29) == 0);
      rv.lat = -1;
      ev = model(rv);
      if (rv.nan || rv.inf || (rv.mant == 56'h0)) ev.lat = -1;
      run_op($sformatf("rnd%0d", i), rv, ev);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
